// File: rtl/memory_broadcast_responder.sv
// -----------------------------------------------------------------------------
// memory_broadcast_responder
//
// Purpose:
//   Serves cache-line read requests from N_PORTS requesters one at a time.
//   A round-robin arbiter picks a pending requester. Its line is read from
//   backing memory, and the returned line is broadcast to all caches. The
//   granted port receives a one-cycle req_ready pulse in the same cycle as
//   the broadcast strobe.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst            - asynchronous, active-high reset
//   req_valid      - per-port request, held until served
//   req_addr       - per-port line address, port i at [i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH]
//   req_ready      - one-cycle grant/acknowledge pulse, one-hot
//   mem_req_valid  - backing-memory read request
//   mem_req_addr   - backing-memory line address
//   mem_req_ready  - memory accepts request when valid & ready
//   mem_resp_valid - one-cycle read-return strobe
//   mem_resp_data  - returned line
//   bcast_valid    - one-cycle broadcast strobe
//   bcast_addr     - broadcast line address
//   bcast_data     - broadcast line data
// -----------------------------------------------------------------------------
module memory_broadcast_responder #(
    parameter int N_PORTS         = 4,
    parameter int LINE_ADDR_WIDTH = 12,
    parameter int LINE_WIDTH      = 64,
    parameter int PTR_WIDTH       = $clog2(N_PORTS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_PORTS-1:0]                 req_valid,
    input  logic [N_PORTS*LINE_ADDR_WIDTH-1:0] req_addr,
    output logic [N_PORTS-1:0]                 req_ready,
    output logic                               mem_req_valid,
    output logic [LINE_ADDR_WIDTH-1:0]         mem_req_addr,
    input  logic                               mem_req_ready,
    input  logic                               mem_resp_valid,
    input  logic [LINE_WIDTH-1:0]              mem_resp_data,
    output logic                               bcast_valid,
    output logic [LINE_ADDR_WIDTH-1:0]         bcast_addr,
    output logic [LINE_WIDTH-1:0]              bcast_data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_REQ  = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_BCAST    = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;

    logic [PTR_WIDTH-1:0]         r_rr_ptr;
    logic [PTR_WIDTH-1:0]         r_grant;
    logic [LINE_ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_ADDR_WIDTH-1:0]   r_bcast_addr;
    logic [LINE_WIDTH-1:0]        r_bcast_data;
    logic [N_PORTS-1:0]           r_req_ready;
    logic                         r_mem_req_valid;
    logic                         r_bcast_valid;

    logic                         w_found;
    logic [PTR_WIDTH-1:0]         w_grant_idx;
    logic [LINE_ADDR_WIDTH-1:0]   w_req_addr_sel;
    logic [PTR_WIDTH-1:0]         w_ptr_next;
    logic [N_PORTS-1:0]           w_grant_onehot;
    logic [N_PORTS-1:0]           w_next_req_ready;
    logic                         w_next_mem_req_valid;
    logic                         w_next_bcast_valid;

    // Round-robin search: first requesting port at or after r_rr_ptr, wrapping.
    always_comb begin : rr_search
        logic [PTR_WIDTH:0]   v_sum;
        logic [PTR_WIDTH-1:0] v_idx;
        w_found     = 1'b0;
        w_grant_idx = r_rr_ptr;
        v_sum       = '0;
        v_idx       = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            v_sum = {1'b0, r_rr_ptr} + (PTR_WIDTH+1)'(i);
            // Modulo N_PORTS without a divider: the sum is below 2*N_PORTS.
            if (v_sum >= (PTR_WIDTH+1)'(N_PORTS)) begin
                v_sum = v_sum - (PTR_WIDTH+1)'(N_PORTS);
            end else begin
                v_sum = v_sum;
            end
            v_idx = v_sum[PTR_WIDTH-1:0];
            if (!w_found && req_valid[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = v_idx;
            end else begin
                w_found     = w_found;
            end
        end
        w_req_addr_sel = req_addr[w_grant_idx*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
    end

    // Pointer advance past the served port and its one-hot acknowledge.
    always_comb begin
        w_ptr_next     = '0;
        w_grant_onehot = '0;
        if (r_grant == PTR_WIDTH'(N_PORTS - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_grant + PTR_WIDTH'(1);
        end
        w_grant_onehot[r_grant] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus next values of the registered strobes.
    always_comb begin
        w_next_state         = r_state;
        w_next_req_ready     = '0;
        w_next_mem_req_valid = 1'b0;
        w_next_bcast_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_MEM_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready) begin
                    w_next_state = S_MEM_WAIT;
                end else begin
                    w_next_state = S_MEM_REQ;
                end
            end
            S_MEM_WAIT: begin
                // Responses are only meaningful here; elsewhere they are ignored.
                if (mem_resp_valid) begin
                    w_next_state = S_BCAST;
                end else begin
                    w_next_state = S_MEM_WAIT;
                end
            end
            S_BCAST: begin
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave a flop
        // in the same cycle the FSM occupies the matching state.
        if (w_next_state == S_BCAST) begin
            w_next_req_ready   = w_grant_onehot;
            w_next_bcast_valid = 1'b1;
        end else begin
            w_next_req_ready   = '0;
            w_next_bcast_valid = 1'b0;
        end
        if (w_next_state == S_MEM_REQ) begin
            w_next_mem_req_valid = 1'b1;
        end else begin
            w_next_mem_req_valid = 1'b0;
        end
    end

    // Registered strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready     <= '0;
            r_mem_req_valid <= 1'b0;
            r_bcast_valid   <= 1'b0;
        end else begin
            r_req_ready     <= w_next_req_ready;
            r_mem_req_valid <= w_next_mem_req_valid;
            r_bcast_valid   <= w_next_bcast_valid;
        end
    end

    // Grant latch, broadcast payload capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_addr       <= '0;
            r_rr_ptr     <= '0;
            r_bcast_addr <= '0;
            r_bcast_data <= '0;
        end else begin
            // Address is latched at grant so a requester may drop or change
            // req_addr afterwards without disturbing the transaction.
            if ((r_state == S_IDLE) && w_found) begin
                r_grant <= w_grant_idx;
                r_addr  <= w_req_addr_sel;
            end
            // Payload changes only on entry to S_BCAST, so it stays stable
            // through the strobe cycle and the following hold cycle.
            if ((r_state == S_MEM_WAIT) && mem_resp_valid) begin
                r_bcast_data <= mem_resp_data;
                r_bcast_addr <= r_addr;
            end
            if (r_state == S_BCAST) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    assign req_ready     = r_req_ready;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_addr;
    assign bcast_valid   = r_bcast_valid;
    assign bcast_addr    = r_bcast_addr;
    assign bcast_data    = r_bcast_data;

endmodule

// File: tb/tb_memory_broadcast_responder.sv
// -----------------------------------------------------------------------------
// Testbench for memory_broadcast_responder: directed vector table, hand-written
// corner sequences, and a randomized phase against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_memory_broadcast_responder;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int LW = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      req_ready;
    logic              mem_req_valid;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_ready = 1'b0;
    logic              mem_resp_valid = 1'b0;
    logic [LW-1:0]     mem_resp_data = '0;
    logic              bcast_valid;
    logic [AW-1:0]     bcast_addr;
    logic [LW-1:0]     bcast_data;

    int n_checks = 0;
    int n_errors = 0;

    memory_broadcast_responder #(
        .N_PORTS(N), .LINE_ADDR_WIDTH(AW), .LINE_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .bcast_valid(bcast_valid), .bcast_addr(bcast_addr), .bcast_data(bcast_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*AW-1:0] addrs;
        int              stall;
        int              lat;
        logic [LW-1:0]   data;
        bit              drop;
        int              exp_port;
        logic [AW-1:0]   exp_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] mask, input logic [N*AW-1:0] addrs,
                                input int stall, input int lat, input logic [LW-1:0] data,
                                input bit drop, input int exp_port, input logic [AW-1:0] exp_addr);
        vec_t v;
        v.mask = mask; v.addrs = addrs; v.stall = stall; v.lat = lat; v.data = data;
        v.drop = drop; v.exp_port = exp_port; v.exp_addr = exp_addr;
        return v;
    endfunction

    task automatic wait_mrv(input string name);
        int w = 0;
        while (mem_req_valid !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        chk(name, {63'd0, mem_req_valid}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        logic [N-1:0] oh;
        oh = '0;
        oh[v.exp_port] = 1'b1;
        req_addr = v.addrs;
        req_valid = v.mask;
        mem_req_ready = 1'b0;
        wait_mrv({tag, "_mrv"});
        chk({tag, "_maddr"}, {52'd0, mem_req_addr}, {52'd0, v.exp_addr});
        if (v.drop) req_valid = '0;
        for (int s = 0; s < v.stall; s++) begin
            tick();
            chk({tag, "_stall_mrv"}, {63'd0, mem_req_valid}, 64'd1);
            chk({tag, "_stall_addr"}, {52'd0, mem_req_addr}, {52'd0, v.exp_addr});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk({tag, "_accepted"}, {63'd0, mem_req_valid}, 64'd0);
        for (int l = 0; l < v.lat - 1; l++) begin
            tick();
            chk({tag, "_wait_bv"}, {63'd0, bcast_valid}, 64'd0);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data = v.data;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        req_valid = '0;
        chk({tag, "_bvalid"}, {63'd0, bcast_valid}, 64'd1);
        chk({tag, "_baddr"}, {52'd0, bcast_addr}, {52'd0, v.exp_addr});
        chk({tag, "_bdata"}, bcast_data, v.data);
        chk({tag, "_rready"}, {60'd0, req_ready}, {60'd0, oh});
        tick();
        chk({tag, "_hold_bv"}, {63'd0, bcast_valid}, 64'd0);
        chk({tag, "_hold_data"}, bcast_data, v.data);
        chk({tag, "_hold_addr"}, {52'd0, bcast_addr}, {52'd0, v.exp_addr});
        chk({tag, "_hold_rr"}, {60'd0, req_ready}, 64'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rr"}, {60'd0, req_ready}, 64'd0);
        chk({tag, "_mrv"}, {63'd0, mem_req_valid}, 64'd0);
        chk({tag, "_maddr"}, {52'd0, mem_req_addr}, 64'd0);
        chk({tag, "_bv"}, {63'd0, bcast_valid}, 64'd0);
        chk({tag, "_baddr"}, {52'd0, bcast_addr}, 64'd0);
        chk({tag, "_bdata"}, bcast_data, 64'd0);
    endtask

    // Randomized traffic checked against a transaction-level model.
    task automatic random_phase();
        logic [N-1:0]  rv = '0;
        logic [AW-1:0] ra [N];
        logic [N-1:0]  s_valid;
        logic [AW-1:0] s_addr [N];
        bit            s_ready, s_resp, s_real;
        logic [LW-1:0] s_data;
        logic [LW-1:0] last_bd = '0;
        logic [AW-1:0] last_ba = '0;
        logic [AW-1:0] exp_addr = '0;
        logic [N-1:0]  oh;
        int  ptr = 0, exp_port = 0, cnt = 0, done = 0, cyc = 0, last_bc = -10, idle_wait = 0;
        bit  busy = 0, pending = 0, found;
        for (int p = 0; p < N; p++) ra[p] = '0;
        while (done < 40 && cyc < 4000) begin
            for (int p = 0; p < N; p++) begin
                if (!rv[p] && !(busy && p == exp_port) && $urandom_range(0, 3) == 0) begin
                    rv[p] = 1'b1;
                    ra[p] = AW'($urandom);
                end else if (busy && p == exp_port && rv[p] && $urandom_range(0, 7) == 0) begin
                    rv[p] = 1'b0;
                end
            end
            s_ready = ($urandom_range(0, 2) != 0);
            s_resp = 1'b0;
            s_real = 1'b0;
            s_data = {$urandom, $urandom};
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    s_resp = 1'b1;
                    s_real = 1'b1;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                s_resp = 1'b1;
            end
            req_valid = rv;
            for (int p = 0; p < N; p++) req_addr[p*AW +: AW] = ra[p];
            mem_req_ready = s_ready;
            mem_resp_valid = s_resp;
            mem_resp_data = s_data;
            s_valid = rv;
            for (int p = 0; p < N; p++) s_addr[p] = ra[p];
            tick();
            cyc++;
            if (pending) begin
                if (s_ready) begin
                    chk("rnd_accept", {63'd0, mem_req_valid}, 64'd0);
                    pending = 0;
                    cnt = $urandom_range(1, 4);
                end else begin
                    chk("rnd_stall_mrv", {63'd0, mem_req_valid}, 64'd1);
                    chk("rnd_stall_addr", {52'd0, mem_req_addr}, {52'd0, exp_addr});
                end
            end else if (!busy) begin
                if (mem_req_valid === 1'b1) begin
                    chk("rnd_grant_had_req", {63'd0, (s_valid != '0)}, 64'd1);
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && s_valid[(ptr + k) % N]) begin
                            found = 1;
                            exp_port = (ptr + k) % N;
                        end
                    end
                    exp_addr = s_addr[exp_port];
                    chk("rnd_maddr", {52'd0, mem_req_addr}, {52'd0, exp_addr});
                    busy = 1;
                    pending = 1;
                    idle_wait = 0;
                end else if (s_valid != '0) begin
                    idle_wait++;
                    if (idle_wait > 4) begin
                        chk("rnd_grant_liveness", 64'd0, 64'd1);
                        idle_wait = 0;
                    end
                end else begin
                    idle_wait = 0;
                end
            end else begin
                chk("rnd_wait_mrv", {63'd0, mem_req_valid}, 64'd0);
            end
            if (s_real) begin
                oh = '0;
                oh[exp_port] = 1'b1;
                chk("rnd_bvalid", {63'd0, bcast_valid}, 64'd1);
                chk("rnd_baddr", {52'd0, bcast_addr}, {52'd0, exp_addr});
                chk("rnd_bdata", bcast_data, s_data);
                chk("rnd_rready", {60'd0, req_ready}, {60'd0, oh});
                chk("rnd_spacing", {63'd0, (cyc - last_bc >= 3)}, 64'd1);
                last_bc = cyc;
                ptr = (exp_port + 1) % N;
                busy = 0;
                rv[exp_port] = 1'b0;
                last_bd = s_data;
                last_ba = exp_addr;
                done++;
            end else begin
                chk("rnd_no_bvalid", {63'd0, bcast_valid}, 64'd0);
                chk("rnd_no_rready", {60'd0, req_ready}, 64'd0);
                chk("rnd_bdata_stable", bcast_data, last_bd);
                chk("rnd_baddr_stable", {52'd0, bcast_addr}, {52'd0, last_ba});
            end
        end
        chk("rnd_progress", {63'd0, (done >= 40)}, 64'd1);
        req_valid = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] oh;
        vecs[0] = mk(4'b0010, {12'h333, 12'h222, 12'h0A5, 12'h111}, 0, 2, 64'hDEAD_BEEF_0000_0001, 1'b0, 1, 12'h0A5);
        vecs[1] = mk(4'b1111, {12'h403, 12'h402, 12'h401, 12'h400}, 0, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 2, 12'h402);
        vecs[2] = mk(4'b1111, {12'h503, 12'h502, 12'h501, 12'h500}, 0, 3, 64'hFFFF_0000_FFFF_0000, 1'b0, 3, 12'h503);
        vecs[3] = mk(4'b1111, {12'h603, 12'h602, 12'h601, 12'h600}, 0, 1, 64'h5555_AAAA_5555_AAAA, 1'b0, 0, 12'h600);
        vecs[4] = mk(4'b0001, {12'h703, 12'h702, 12'h701, 12'h7FF}, 1, 1, 64'h0000_0000_0000_0001, 1'b0, 0, 12'h7FF);
        vecs[5] = mk(4'b1000, {12'hFFF, 12'h802, 12'h801, 12'h800}, 5, 2, 64'h8000_0000_0000_0000, 1'b0, 3, 12'hFFF);
        vecs[6] = mk(4'b0110, {12'h903, 12'h902, 12'h901, 12'h900}, 0, 4, 64'hCAFE_F00D_1234_5678, 1'b1, 1, 12'h901);
        vecs[7] = mk(4'b0010, {12'hA03, 12'hA02, 12'hA01, 12'hA00}, 2, 1, 64'h1111_2222_3333_4444, 1'b0, 1, 12'hA01);
        vecs[8] = mk(4'b0101, {12'hB03, 12'hB02, 12'hB01, 12'hB00}, 0, 2, 64'h9999_8888_7777_6666, 1'b0, 2, 12'hB02);

        // Reset state, checked while rst is still asserted.
        #3;
        check_all_zero("reset");
        do_reset();
        check_all_zero("post_reset");

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // All ports requesting continuously: grants 0,1,2,3,0.
        do_reset();
        req_addr = {12'hC03, 12'hC02, 12'hC01, 12'hC00};
        req_valid = 4'b1111;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_mrv("rr_mrv");
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_data = 64'(k + 100);
            tick();
            mem_resp_valid = 1'b0;
            oh = '0;
            oh[k % N] = 1'b1;
            chk($sformatf("rr_grant%0d", k), {60'd0, req_ready}, {60'd0, oh});
            chk($sformatf("rr_bvalid%0d", k), {63'd0, bcast_valid}, 64'd1);
            tick();
        end
        req_valid = '0;
        mem_req_ready = 1'b0;
        tick();
        tick();

        // Spurious response while idle.
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("spur_bvalid", {63'd0, bcast_valid}, 64'd0);
            chk("spur_bdata", bcast_data, 64'd104);
            tick();
        end

        // Reset while waiting for memory; late response must not broadcast.
        req_addr = {12'hD03, 12'hD02, 12'hD01, 12'hD00};
        req_valid = 4'b1111;
        mem_req_ready = 1'b1;
        wait_mrv("rstmf_mrv");
        chk("rstmf_maddr", {52'd0, mem_req_addr}, 64'hD01);
        tick();
        mem_req_ready = 1'b0;
        chk("rstmf_in_wait", {63'd0, mem_req_valid}, 64'd0);
        #2;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_all_zero("rstmf_async");
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'h7777_7777_7777_7777;
        tick();
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_all_zero("rstmf_after");
            tick();
        end
        do_txn(mk(4'b1111, {12'hE03, 12'hE02, 12'hE01, 12'hE00}, 0, 1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 0, 12'hE00), "rstmf_next");

        // Randomized phase from a clean reset.
        do_reset();
        random_phase();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_broadcast_responder.md
MEMORY_BROADCAST_RESPONDER -- requirements
Module: memory_broadcast_responder

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of cache requesters, at least 2.
REQ-002 SHALL have parameter LINE_ADDR_WIDTH, default 12: width of a cache-line (block) address.
REQ-003 SHALL have parameter LINE_WIDTH, default 64: bits per cache line.
REQ-004 SHALL have parameter PTR_WIDTH, derived as $clog2(N_PORTS).
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  N_PORTS  per-port line request; held until served.
REQ-008 req_addr  in  N_PORTS*LINE_ADDR_WIDTH  per-port line address; port i at slice [i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH].
REQ-009 req_ready  out  N_PORTS  one-cycle per-port grant/acknowledge pulse.
REQ-010 mem_req_valid  out  1  backing-memory read request.
REQ-011 mem_req_addr  out  LINE_ADDR_WIDTH  backing-memory line address.
REQ-012 mem_req_ready  in  1  memory accepts the request in a cycle where mem_req_valid=1 and mem_req_ready=1.
REQ-013 mem_resp_valid  in  1  one-cycle read-return strobe; arbitrary latency, at least 1 cycle after acceptance.
REQ-014 mem_resp_data  in  LINE_WIDTH  returned line; valid only with mem_resp_valid.
REQ-015 bcast_valid  out  1  one-cycle broadcast strobe to all caches.
REQ-016 bcast_addr  out  LINE_ADDR_WIDTH  address of the broadcast line.
REQ-017 bcast_data  out  LINE_WIDTH  broadcast line, registered.

Function
REQ-018 SHALL implement FSM states S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_BCAST, S_HOLD.
REQ-019 In S_IDLE, if any req_valid bit is set, SHALL grant round-robin.
  - Search starts at port rr_ptr, ascending, wrapping from N_PORTS-1 to 0.
  - Latch grant index and req_addr of the granted port.
  - Go to S_MEM_REQ.
REQ-020 If no req_valid bit is set in S_IDLE, SHALL remain in S_IDLE.
REQ-021 In S_MEM_REQ:
  - mem_req_valid=1, mem_req_addr=latched address.
  - On mem_req_ready, go to S_MEM_WAIT.
  - Otherwise hold mem_req_valid and mem_req_addr stable.
REQ-022 In S_MEM_WAIT, on mem_resp_valid SHALL register mem_resp_data into bcast_data and go to S_BCAST.
REQ-023 SHALL ignore mem_resp_valid in every state except S_MEM_WAIT.
REQ-024 In S_BCAST, for exactly one cycle:
  - bcast_valid=1.
  - bcast_addr=latched address.
  - req_ready[grant]=1; all other req_ready bits 0.
  - rr_ptr <= (grant+1) mod N_PORTS.
  - Go to S_HOLD.
REQ-025 In S_HOLD, SHALL keep bcast_data and bcast_addr unchanged and go to S_IDLE; receiving caches sample data in the cycle after the strobe.
REQ-026 bcast_data and bcast_addr SHALL change only on entry to S_BCAST.
  - Consecutive bcast_valid pulses are separated by at least 3 cycles.
REQ-027 Minimum latency from req_valid rising in S_IDLE to req_ready SHALL be 4 cycles, with mem_req_ready=1 and 1-cycle memory latency.
REQ-028 A granted request whose req_valid drops before S_BCAST SHALL still complete its memory read and broadcast.
REQ-029 SHALL NOT merge or filter duplicate addresses; caches that snoop the broadcast absorb duplicates.
REQ-030 req_ready SHALL be 0 in every state other than S_BCAST.
REQ-031 mem_req_valid SHALL be 0 in every state other than S_MEM_REQ.

Reset
REQ-032 While rst=1, the following SHALL hold, independent of clk:
  - state=S_IDLE, rr_ptr=0.
  - req_ready=0, mem_req_valid=0, bcast_valid=0.
  - bcast_addr=0, bcast_data=0.
REQ-033 Reset during S_MEM_WAIT SHALL abandon the transaction; a later mem_resp_valid SHALL produce no broadcast.

Verification
REQ-034 Single request: port1 req_addr=0x0A5, mem_req_ready=1, response 2 cycles after acceptance with data 0xDEAD_BEEF_0000_0001.
  - Required: mem_req_addr=0x0A5.
  - Required: one bcast_valid with bcast_addr=0x0A5 and req_ready=4'b0010.
  - Required: bcast_data stable for the strobe cycle and the next cycle.
REQ-035 Round-robin: all 4 ports valid continuously -> grants in order 0,1,2,3,0; each req_ready pulse is one-hot.
REQ-036 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid stays 1 and mem_req_addr stays stable; the request is accepted on the 6th cycle.
REQ-037 Spurious response: mem_resp_valid pulsed in S_IDLE -> no bcast_valid and bcast_data unchanged.
REQ-038 Reset mid-flight: rst pulsed in S_MEM_WAIT, then mem_resp_valid -> all outputs 0 and no broadcast; the next request is granted to port 0 first.
